// File: rtl/bitvault_pkg.sv
// Shared types and default widths for the BitVault two-port arbiter.
// The read-only mask feature is enabled by the macro BITVAULT_RO_MASK_EN.
package bitvault_pkg;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Control half of the command stage; address and data sit beside it at the
    // instance's parameterised widths.
    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   we;
    } cmd_t;

    function automatic owner_t grant_owner(input logic grant_b);
        return grant_b ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/bitvault_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, PRI_A/PRI_B priority state.
module bitvault_rr_arb
    import bitvault_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    pri_state_t pri;

    // Grants are held low while reset is asserted so no request is accepted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (req_a && (!req_b || pri == PRI_A)) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= PRI_A;
        end else begin
            case (pri)
                PRI_A:   if (grant_a) pri <= PRI_B;
                                else if (grant_b) pri <= PRI_A;
                PRI_B:   if (grant_b) pri <= PRI_A;
                                else if (grant_a) pri <= PRI_B;
                default: pri <= PRI_A;
            endcase
        end
    end

endmodule

// File: rtl/bitvault_port_arbiter.sv
// Two-requester front end for the 4x8 BitVault register file: round-robin grant,
// registered command stage, response demux. Optional macro: BITVAULT_RO_MASK_EN.
module bitvault_port_arbiter
    import bitvault_pkg::*;
#(
    parameter int unsigned           AW      = bitvault_pkg::AW,
    parameter int unsigned           DW      = bitvault_pkg::DW,
    parameter logic [(2**AW)-1:0]    RO_MASK = '0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_rdata,
    output logic          a_rsp_err,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_rdata,
    output logic          b_rsp_err,

    output logic [AW-1:0] rf_addr,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    logic          grant_a;
    logic          grant_b;
    logic          accept;

    cmd_t          cmd;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          ro_hit;

    logic          rsp_valid;
    owner_t        rsp_owner;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    bitvault_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign accept  = grant_a | grant_b;

    // Address/data only load on acceptance so idle cycles hold the last rf_addr/rf_wdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else begin
            cmd.valid <= accept;
            if (accept) begin
                cmd.owner <= grant_owner(grant_b);
                cmd.we    <= grant_b ? b_we : a_we;
                cmd_addr  <= grant_b ? b_addr : a_addr;
                cmd_wdata <= grant_b ? b_wdata : a_wdata;
            end
        end
    end

`ifdef BITVAULT_RO_MASK_EN
    assign ro_hit = RO_MASK[cmd_addr];
`else
    assign ro_hit = 1'b0;
`endif

    // Built from reset-cleared flops, so asserting rst_n drops rf_we immediately.
    assign rf_addr  = cmd_addr;
    assign rf_wdata = cmd_wdata;
    assign rf_we    = cmd.valid & cmd.we & ~ro_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_owner <= OWN_A;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= cmd.valid;
            rsp_owner <= cmd.owner;
            rsp_rdata <= (cmd.valid && !cmd.we) ? rf_rdata : '0;
            rsp_err   <= cmd.valid & cmd.we & ro_hit;
        end
    end

    always_comb begin
        a_rsp_valid = rsp_valid && (rsp_owner == OWN_A);
        b_rsp_valid = rsp_valid && (rsp_owner == OWN_B);
        a_rsp_rdata = a_rsp_valid ? rsp_rdata : '0;
        b_rsp_rdata = b_rsp_valid ? rsp_rdata : '0;
        a_rsp_err   = a_rsp_valid & rsp_err;
        b_rsp_err   = b_rsp_valid & rsp_err;
    end

endmodule
